// File: rtl/serial_mac_pkg.sv
// rtl/serial_mac_pkg.sv - shared state encoding and default widths for the bit-serial MAC
package serial_mac_pkg;

  localparam int OP_W_DEF  = 8;
  localparam int ACC_W_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_ACC,
    ST_OUT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/serial_mac_if.sv
// rtl/serial_mac_if.sv - pin-level serial MAC bundle: control/operand pins in, result stream and flags out
interface serial_mac_if;

  logic start;
  logic clear_acc;
  logic ser_a;
  logic ser_b;
  logic ser_out;
  logic ser_valid;
  logic busy;
  logic done;
  logic carry_out;

  modport master (
    output start, clear_acc, ser_a, ser_b,
    input  ser_out, ser_valid, busy, done, carry_out
  );

  modport slave (
    input  start, clear_acc, ser_a, ser_b,
    output ser_out, ser_valid, busy, done, carry_out
  );

endinterface

// File: rtl/serial_mac_mult.sv
// rtl/serial_mac_mult.sv - OP_W-cycle unsigned shift-add multiplier; operands captured on start_i
module serial_mac_mult
  import serial_mac_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [2*OP_W-1:0] product_o,
  output logic              done_o
);

  localparam int CW = $clog2(OP_W + 1);

  logic [2*OP_W-1:0] mcand_q, mcand_d;
  logic [2*OP_W-1:0] prod_q, prod_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d;

  // High while the last multiplier bit is being folded in; product_o is final the cycle after.
  assign done_o    = run_q && (cnt_q == CW'(OP_W - 1));
  assign product_o = prod_q;

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      mcand_d  = {{OP_W{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done_o) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/serial_mac_core.sv
// rtl/serial_mac_core.sv - bit-serial MAC controller, operand shifters, accumulator and serialiser; SERIAL_MAC_SAT_EN selects saturating accumulate
module serial_mac_core
  import serial_mac_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input logic         clock,
  input logic         reset_n,
  serial_mac_if.slave bus
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  generate
    if (ACC_W < 2 * OP_W) begin : g_width_check
      $error("serial_mac_core: ACC_W must be at least 2*OP_W");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     op_a_q, op_a_d;
  logic [OP_W-1:0]     op_b_q, op_b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                carry_q, carry_d;
  logic                mult_start;
  logic                mult_done;
  logic [2*OP_W-1:0]   product;
  logic [ACC_W:0]      sum_w;
  logic [ACC_W-1:0]    acc_shift;

  // The multiplier latches the operand values being completed on the final LOAD edge.
  serial_mac_mult #(
    .OP_W (OP_W)
  ) u_mult (
    .clock     (clock),
    .reset_n   (reset_n),
    .start_i   (mult_start),
    .a_i       (op_a_d),
    .b_i       (op_b_d),
    .product_o (product),
    .done_o    (mult_done)
  );

  assign sum_w     = {1'b0, acc_q} + (ACC_W + 1)'(product);
  assign acc_shift = acc_q >> cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    mult_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear_acc) begin
          acc_d   = '0;
          carry_d = 1'b0;
        end
        if (bus.start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        op_a_d = {bus.ser_a, op_a_q[OP_W-1:1]};
        op_b_d = {bus.ser_b, op_b_q[OP_W-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OP_W - 1)) begin
          state_d    = ST_MUL;
          cnt_d      = '0;
          mult_start = 1'b1;
        end
      end
      ST_MUL: begin
        if (mult_done) begin
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
`ifdef SERIAL_MAC_SAT_EN
        acc_d = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
        acc_d = sum_w[ACC_W-1:0];
`endif
        carry_d = carry_q | sum_w[ACC_W];
        state_d = ST_OUT;
        cnt_d   = '0;
      end
      ST_OUT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ACC_W - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  // Outputs decode the registered state so an asserted reset silences them immediately.
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.ser_valid = (state_q == ST_OUT);
  assign bus.ser_out   = (state_q == ST_OUT) & acc_shift[0];
  assign bus.done      = (state_q == ST_DONE);
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_serial_mac_core.sv
// tb/tb_serial_mac_core.sv - self-checking bench for serial_mac_core against an arithmetic accumulator model
module tb_serial_mac_core;

  localparam int OP_W  = 8;
  localparam int ACC_W = 20;
  localparam int LAT   = 2 * OP_W + ACC_W + 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  serial_mac_if bus ();

  serial_mac_core #(
    .OP_W  (OP_W),
    .ACC_W (ACC_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint m_acc    = 0;
  logic   m_carry  = 1'b0;
  longint got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input bit clr);
    longint sum;
    longint lim;
    lim = longint'(1) << ACC_W;
    if (clr) begin
      m_acc   = 0;
      m_carry = 1'b0;
    end
    sum = m_acc + longint'(a) * longint'(b);
    if (sum >= lim) begin
      m_carry = 1'b1;
`ifdef SERIAL_MAC_SAT_EN
      m_acc = lim - 1;
`else
      m_acc = sum - lim;
`endif
    end else begin
      m_acc = sum;
    end
  endtask

  // Called one step after an edge with the DUT idle; returns in the idle cycle after DONE.
  task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input bit clr,
                        input bit spam, input int abort_cyc, output longint res);
    int done_cyc = -1;
    int nbits    = 0;
    bit bad_busy = 1'b0;
    bit bad_out  = 1'b0;
    res = 0;
    model_apply(a, b, clr);
    bus.start     = 1'b1;
    bus.clear_acc = clr;
    for (int cyc = 1; cyc <= LAT + 20; cyc++) begin
      @(posedge clock);
      #1;
      if (cyc == abort_cyc) begin
        check("abort_pre_valid", bus.ser_valid, 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_ser_valid", bus.ser_valid, 0);
        check("abort_ser_out", bus.ser_out, 0);
        check("abort_done", bus.done, 0);
        m_acc   = 0;
        m_carry = 1'b0;
        bus.start     = 1'b0;
        bus.clear_acc = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("abort_carry", bus.carry_out, 0);
        return;
      end
      bus.start     = spam && (cyc <= LAT);
      bus.clear_acc = spam && (cyc <= LAT);
      bus.ser_a     = (cyc <= OP_W) ? a[cyc-1] : 1'($urandom);
      bus.ser_b     = (cyc <= OP_W) ? b[cyc-1] : 1'($urandom);
      if (bus.busy !== 1'b1) bad_busy = 1'b1;
      if (bus.ser_valid === 1'b1) begin
        res = res | (longint'(bus.ser_out) << nbits);
        nbits++;
      end else if (bus.ser_out !== 1'b0) begin
        bad_out = 1'b1;
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    bus.start     = 1'b0;
    bus.clear_acc = 1'b0;
    check("done_latency", done_cyc, LAT);
    check("ser_bit_count", nbits, ACC_W);
    check("busy_while_active", bad_busy, 0);
    check("ser_out_quiet", bad_out, 0);
    check("result", res, m_acc);
    check("carry_out", bus.carry_out, m_carry);
    @(posedge clock);
    #1;
    check("idle_after_done", bus.busy, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.clear_acc = 1'b0;
    bus.ser_a     = 1'b0;
    bus.ser_b     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ser_valid", bus.ser_valid, 0);
    check("rst_ser_out", bus.ser_out, 0);
    check("rst_carry", bus.carry_out, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_op(8'd3, 8'd5, 1'b1, 1'b0, 0, got);
    check("a3_b5_value", got, 15);

    run_op(8'd255, 8'd255, 1'b1, 1'b0, 0, got);
    run_op(8'd255, 8'd255, 1'b0, 1'b0, 0, got);
    check("twice_255_value", got, 130050);
    check("twice_255_carry", bus.carry_out, 0);

    run_op(8'd255, 8'd255, 1'b1, 1'b0, 0, got);
    for (int i = 2; i <= 17; i++) begin
      run_op(8'd255, 8'd255, 1'b0, 1'b0, 0, got);
    end
`ifdef SERIAL_MAC_SAT_EN
    check("overflow_value", got, 1048575);
`else
    check("overflow_value", got, 56849);
`endif
    check("overflow_carry", bus.carry_out, 1);

    bus.clear_acc = 1'b1;
    @(posedge clock);
    #1;
    bus.clear_acc = 1'b0;
    check("clear_alone_carry", bus.carry_out, 0);
    m_acc   = 0;
    m_carry = 1'b0;
    run_op(8'd1, 8'd1, 1'b0, 1'b0, 0, got);
    check("after_clear_value", got, 1);

    run_op(8'($urandom), 8'($urandom), 1'b0, 1'b1, 0, got);
    repeat (3) begin
      @(posedge clock);
      #1;
      check("spam_no_extra_done", bus.done, 0);
      check("spam_stays_idle", bus.busy, 0);
    end

    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0, got);
    end

    run_op(8'($urandom), 8'($urandom), 1'b0, 1'b0, 2 * OP_W + 2 + 4, got);
    run_op(8'd2, 8'd2, 1'b0, 1'b0, 0, got);
    check("post_abort_value", got, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
